// File: rtl/wb_dest_queue_if.sv
// Write-back destination queue bus: producer-side enqueue, register-file drain,
// and hazard-side status (pending mask, occupancy).
interface wb_dest_queue_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          enq_valid;
  logic          enq_ready;
  logic [4:0]    enq_addr;
  logic [DW-1:0] enq_data;
  logic          flush;
  logic          wr_stall;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   pending;
  logic [CW-1:0] count;

  // Queue side.
  modport slave (
    input  enq_valid, enq_addr, enq_data, flush, wr_stall,
    output enq_ready, wr_en, wr_addr, wr_data, pending, count
  );

  // Producer / register-file side.
  modport master (
    output enq_valid, enq_addr, enq_data, flush, wr_stall,
    input  enq_ready, wr_en, wr_addr, wr_data, pending, count
  );
endinterface

// File: rtl/wb_dest_queue.sv
// In-order write-back queue in front of the register file's single write port,
// with a per-register pending mask for hazard detection.
module wb_dest_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  wb_dest_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic        wr_en;
  logic        deq_now;
  logic        enq_ready;
  logic        enq_fire;
  logic        deq_fire;
  logic [31:0] pending;

  // Handshake decode. A full queue still accepts when the head drains this cycle.
  always_comb begin
    wr_en     = (count_q != '0);
    deq_now   = wr_en && !bus.wr_stall;
    enq_ready = (count_q < CW'(DEPTH)) || deq_now;
    // Writes to r0 are acknowledged but never stored.
    enq_fire  = bus.enq_valid && enq_ready && !bus.flush && (bus.enq_addr != 5'd0);
    deq_fire  = deq_now && !bus.flush;
  end

  // Pending mask: an entry is live when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] offset;
    pending = '0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head_q;
      if ({1'b0, offset} < count_q) pending[addr_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        addr_d[tail_q] = bus.enq_addr;
        data_d[tail_q] = bus.enq_data;
        tail_d         = tail_q + PW'(1);
      end
      if (deq_fire) head_d = head_q + PW'(1);
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the entry storage is reset too, so wr_addr/wr_data read 0 out of reset;
  // this costs reset fan-out on a small register array, not a RAM macro.
  // NOTE: sequential state uses non-blocking assignment only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Head entry drives the write port directly, so it is stable under stall.
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = addr_q[head_q];
  assign bus.wr_data   = data_q[head_q];
  assign bus.enq_ready = enq_ready;
  assign bus.pending   = pending;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_wb_dest_queue.sv
// Self-checking bench for wb_dest_queue: directed vector table, hand-written
// reset/flush corners, and randomized traffic against a queue-based model.
module tb_wb_dest_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_dest_queue_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
  wb_dest_queue #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          ev;
    logic [4:0]    ea;
    logic [DW-1:0] ed;
    logic          fl;
    logic          st;
    logic          xen;
    logic [4:0]    xaddr;
    logic [DW-1:0] xdata;
    logic [CW-1:0] xcnt;
    logic          xrdy;
    logic [31:0]   xpend;
  } vec_t;

  function automatic vec_t mk(input logic ev, input logic [4:0] ea, input logic [DW-1:0] ed,
                              input logic fl, input logic st, input logic xen,
                              input logic [4:0] xaddr, input logic [DW-1:0] xdata,
                              input logic [CW-1:0] xcnt, input logic xrdy, input logic [31:0] xpend);
    vec_t v;
    v.ev = ev; v.ea = ea; v.ed = ed; v.fl = fl; v.st = st;
    v.xen = xen; v.xaddr = xaddr; v.xdata = xdata; v.xcnt = xcnt; v.xrdy = xrdy; v.xpend = xpend;
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [4:0] ea, input logic [DW-1:0] ed,
                       input logic fl, input logic st);
    bus.enq_valid = ev;
    bus.enq_addr  = ea;
    bus.enq_data  = ed;
    bus.flush     = fl;
    bus.wr_stall  = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];
  vec_t tbl[$];

  initial begin
    logic [31:0] xp;
    logic        ev, fl, st, rdy;
    logic [4:0]  ea;
    logic [DW-1:0] ed;

    // ---------------- reset ----------------
    rst = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
    #1;
    check("rst_wr_en",   bus.wr_en,     0);
    check("rst_ready",   bus.enq_ready, 1);
    check("rst_pending", bus.pending,   0);
    check("rst_count",   bus.count,     0);
    check("rst_wr_addr", bus.wr_addr,   0);
    check("rst_wr_data", bus.wr_data,   0);
    step();
    rst = 1'b1;

    // ---------------- directed table ----------------
    //                ev  ea     ed            fl st  xen xaddr xdata         xcnt xrdy xpend
    tbl.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 0, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 5'd5, 32'hDEADBEEF, 3'd1, 1, 32'h20));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(1, 5'd1,  32'h101,      0, 1, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(1, 5'd2,  32'h102,      0, 1, 1, 5'd1, 32'h101,      3'd1, 1, 32'h2));
    tbl.push_back(mk(1, 5'd3,  32'h103,      0, 1, 1, 5'd1, 32'h101,      3'd2, 1, 32'h6));
    tbl.push_back(mk(1, 5'd4,  32'h104,      0, 1, 1, 5'd1, 32'h101,      3'd3, 1, 32'hE));
    tbl.push_back(mk(1, 5'd9,  32'h900,      0, 1, 1, 5'd1, 32'h101,      3'd4, 0, 32'h1E));
    tbl.push_back(mk(1, 5'd9,  32'h900,      0, 0, 1, 5'd1, 32'h101,      3'd4, 1, 32'h1E));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 5'd2, 32'h102,      3'd4, 1, 32'h21C));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 5'd3, 32'h103,      3'd3, 1, 32'h218));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 5'd4, 32'h104,      3'd2, 1, 32'h210));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 5'd9, 32'h900,      3'd1, 1, 32'h200));
    tbl.push_back(mk(1, 5'd0,  32'h1234,     0, 0, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(1, 5'd7,  32'h1,        0, 1, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(1, 5'd7,  32'h2,        0, 1, 1, 5'd7, 32'h1,        3'd1, 1, 32'h80));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 5'd7, 32'h1,        3'd2, 1, 32'h80));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 5'd7, 32'h2,        3'd1, 1, 32'h80));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(1, 5'd10, 32'hA0,       0, 1, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));
    tbl.push_back(mk(1, 5'd11, 32'hB0,       0, 1, 1, 5'd10, 32'hA0,      3'd1, 1, 32'h400));
    tbl.push_back(mk(1, 5'd12, 32'hC0,       0, 1, 1, 5'd10, 32'hA0,      3'd2, 1, 32'hC00));
    tbl.push_back(mk(1, 5'd13, 32'hD0,       1, 1, 1, 5'd10, 32'hA0,      3'd3, 1, 32'h1C00));
    tbl.push_back(mk(0, 5'd0,  32'h0,        0, 0, 0, 5'd0, 32'h0,        3'd0, 1, 32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].fl, tbl[i].st);
      #1;
      check($sformatf("v%0d_wr_en", i),   bus.wr_en,     tbl[i].xen);
      check($sformatf("v%0d_count", i),   bus.count,     tbl[i].xcnt);
      check($sformatf("v%0d_ready", i),   bus.enq_ready, tbl[i].xrdy);
      check($sformatf("v%0d_pending", i), bus.pending,   tbl[i].xpend);
      if (tbl[i].xen) begin
        check($sformatf("v%0d_wr_addr", i), bus.wr_addr, tbl[i].xaddr);
        check($sformatf("v%0d_wr_data", i), bus.wr_data, tbl[i].xdata);
      end
      step();
    end

    // ---------------- asynchronous reset mid-drain ----------------
    drive(1, 5'd20, 32'h20, 0, 1); step();
    drive(1, 5'd21, 32'h21, 0, 1); step();
    drive(1, 5'd22, 32'h22, 0, 1); step();
    drive(0, 5'd0,  32'h0,  0, 0);
    #1;
    check("mid_pre_count", bus.count, 3);
    check("mid_pre_wr_en", bus.wr_en, 1);
    step();
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en",   bus.wr_en,   0);
    check("mid_rst_count",   bus.count,   0);
    check("mid_rst_pending", bus.pending, 0);
    step();
    check("mid_rst_hold_wr_en", bus.wr_en, 0);
    rst = 1'b1;
    step();
    check("post_rst_count", bus.count, 0);

    // ---------------- randomized traffic vs queue model ----------------
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ev = ($urandom_range(0, 3) != 0);
      ea = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ed = $urandom;
      fl = ($urandom_range(0, 63) == 0);
      st = ((cyc / 40) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      drive(ev, ea, ed, fl, st);
      #1;
      xp = '0;
      foreach (mq[k]) xp[mq[k].addr] = 1'b1;
      rdy = (mq.size() < DEPTH) || (mq.size() != 0 && !st);
      check("rnd_wr_en",   bus.wr_en,     mq.size() != 0);
      check("rnd_count",   bus.count,     mq.size());
      check("rnd_ready",   bus.enq_ready, rdy);
      check("rnd_pending", bus.pending,   xp);
      if (mq.size() != 0) begin
        check("rnd_wr_addr", bus.wr_addr, mq[0].addr);
        check("rnd_wr_data", bus.wr_data, mq[0].data);
      end
      if (fl) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && !st) void'(mq.pop_front());
        if (ev && rdy && ea != 5'd0) mq.push_back('{addr: ea, data: ed});
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_dest_queue.md
# wb_dest_queue

Write-back destination queue between the execution units and the register file's single write port. It buffers (destination register, data) write requests produced after the destination-register selection stage. Requests drain to the register file in order, one per cycle, while the register file does not stall. It also publishes a per-register pending mask so the hazard logic can stall readers of registers with queued writes.

## Interface
- DEPTH, 4: number of queue entries; power of two, at least 2.
- DW, 32: data width of a write-back value.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- enq_valid  input  1  write request present.
- enq_ready  output  1  queue can accept a request this cycle.
- enq_addr  input  5  destination register index.
- enq_data  input  DW  value to write.
- flush  input  1  synchronous clear of all queued entries.
- wr_stall  input  1  register file cannot accept a write this cycle.
- wr_en  output  1  register-file write strobe; head entry valid.
- wr_addr  output  5  head entry register index.
- wr_data  output  DW  head entry value.
- pending  output  32  bit r set iff any valid entry targets register r.
- count  output  clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage is a circular buffer of DEPTH entries, each {addr[4:0], data[DW-1:0]}, with head pointer, tail pointer and count registers. Pointers wrap modulo DEPTH.
- Enqueue fires when enq_valid && enq_ready && !flush. It writes the entry at tail, then tail+1 and count+1.
- A request with enq_addr == 0 is accepted but discarded: no entry is written, count and tail are unchanged, and it never appears on wr_* or pending. Register 0 is hard-wired zero.
- Dequeue fires when wr_en && !wr_stall && !flush. It does head+1 and count−1.
- wr_en = (count != 0). wr_addr and wr_data are read directly from the head entry, so they are stable while wr_stall holds.
- enq_ready = (count < DEPTH) || (wr_en && !wr_stall). When full, a simultaneous drain frees the slot in the same cycle.
- Enqueue and dequeue in the same cycle leave count unchanged and advance both pointers.
- flush takes priority over enqueue and dequeue in the same cycle. The next state is head = tail = 0, count = 0, and the enqueue in that cycle is dropped. Entry contents are don't-care.
- pending is combinational: the OR over valid entries of one-hot(addr). Bit 0 is always 0. Duplicate addresses in the queue keep the bit set until the last matching entry drains.
- Ordering: writes reach the register file in enqueue order. A later write to the same register always lands after an earlier one.

## Timing
- Reset (rst low, asynchronous): head = tail = count = 0. Outputs: wr_en = 0, enq_ready = 1, pending = 0, count = 0. wr_addr and wr_data reset to 0 (entry storage is cleared on reset).
- Latency: a request accepted at edge N appears on wr_* during cycle N+1 if the queue was empty. Its pending bit sets in the same cycle N+1.
- Throughput: one enqueue and one dequeue per cycle sustained.
- A pending bit clears in the cycle after the edge at which its last matching entry drains.
- While wr_stall = 1, wr_en may be 1 but no dequeue occurs. The head entry holds unchanged.
- Reset asserted mid-operation discards all entries immediately. No write strobe is issued after rst falls.

## Test plan
- Reset, then enqueue (addr 5, data 0xDEADBEEF) with wr_stall = 0 → next cycle wr_en = 1, wr_addr = 5, wr_data = 0xDEADBEEF, pending = 0x0000_0020. The cycle after: wr_en = 0, pending = 0.
- wr_stall = 1; enqueue addrs 1, 2, 3, 4 → count = 4, enq_ready = 0, pending = 0x1E. Release the stall → writes emerge as 1, 2, 3, 4 on consecutive cycles.
- Full queue with wr_stall = 0 and enq_valid = 1 (addr 9) on the same cycle → enqueue accepted, count stays 4, and addr 9 emerges last.
- Enqueue addr 0 (data 0x1234) → enq_ready = 1, count unchanged, wr_en never asserts for it, pending bit 0 stays 0.
- Two entries to addr 7 (values 0x1 then 0x2) → pending[7] stays set until the second drains. The register file sees 0x1 then 0x2.
- With 3 entries queued, pulse flush together with enq_valid → next cycle count = 0, wr_en = 0, pending = 0. Separately, assert rst mid-drain → wr_en drops at once and count = 0.
